dma_zx_stream: RTL and testbench
================================

DMA_ZX_STREAM -- requirements
Module: dma_zx_stream

Interface
REQ-001 SHALL have parameter AW, 21, DMA address width, legal range 9..24.
REQ-002 SHALL have parameter CW, 16, transfer counter width, legal range 1..16.
REQ-003 SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port dma_zxread_toggle  in  1  toggles once per ZX DMA read, asynchronous to clk.
REQ-006 SHALL have port dma_zxwrite_toggle  in  1  toggles once per ZX DMA write, asynchronous to clk.
REQ-007 SHALL have port dma_reswait_n  out  1  0 = hold ZX in wait.
REQ-008 SHALL have port dma_data_written  in  8  byte written by ZX, stable when write toggle changes.
REQ-009 SHALL have port dma_data_toberead  out  8  prefetched byte for the next ZX read.
REQ-010 SHALL have port dma_on  out  1  channel enabled.
REQ-011 SHALL have port din  in  8  register write data from ports block.
REQ-012 SHALL have port dout  out  8  register read data, combinational from regsel.
REQ-013 SHALL have port module_select  in  1  module addressed by ports block.
REQ-014 SHALL have port write_strobe  in  1  one-cycle register write strobe.
REQ-015 SHALL have port regsel  in  3  register index.
REQ-016 SHALL have port dma_addr  out  AW  memory address.
REQ-017 SHALL have port dma_wd  out  8  memory write data.
REQ-018 SHALL have port dma_rd  in  8  memory read data, valid with dma_done.
REQ-019 SHALL have port dma_rnw  out  1  1 = read, 0 = write.
REQ-020 SHALL have port dma_req  out  1  memory request, held until ack.
REQ-021 SHALL have port dma_ack  in  1  one-cycle request accepted.
REQ-022 SHALL have port dma_done  in  1  one-cycle transfer complete.

Function
REQ-023 SHALL sync each toggle through 3 flops; event = stage2 != stage1, one per edge.
REQ-024 SHALL set pend_wr/pend_rd on event while dma_on=1; an event with dma_on=0 SHALL be ignored.
REQ-025 SHALL set sticky ovr when an event arrives while its pend flag is still set.
REQ-026 SHALL latch dma_data_written into dma_wd in the cycle the write event is detected.
REQ-027 SHALL drive dma_reswait_n=0 from the cycle after an event until the cycle after the dma_done serving it.
REQ-028 SHALL implement FSM IDLE->REQ->BUSY->IDLE; busy = state != IDLE.
REQ-029 IDLE: pend_wr SHALL win over pend_rd (write first if simultaneous); the chosen flag clears on entering REQ.
REQ-030 REQ: dma_req=1, dma_rnw valid; on dma_ack go BUSY, dma_req=0 from the next cycle.
REQ-031 BUSY: on dma_done go IDLE; read transfers SHALL latch dma_rd into dma_data_toberead.
REQ-032 On dma_ack, dma_addr SHALL step +1, or -1 if dec=1, modulo 2^AW.
REQ-033 On dma_ack, count SHALL decrement if nonzero; on reaching 0 with tc_stop=1, tc SHALL set and dma_on clear on return to IDLE.
REQ-034 Writing dma_on=1 with count=0 and tc_stop=1 SHALL set tc and leave dma_on=0.
REQ-035 Clearing dma_on mid-transfer SHALL clear the pend flags; the in-flight transfer SHALL complete and release reswait.
REQ-036 Registers: regsel 0/1/2 = addr bytes low/mid/high (bits >= AW read 0), 3 = ctrl/status, 4/5 = count low/high (bits >= CW read 0), 6/7 = read 0, writes ignored.
REQ-037 Writes to regsel 0-2 and 4-5 SHALL be ignored while busy.
REQ-038 Ctrl write: bit7 on, bit6 dec, bit5 tc_stop, bit4=1 clears tc and ovr; status read = {on,dec,tc_stop,busy,ovr,tc,2'b00}.

Reset
REQ-039 On rst: FSM IDLE, dma_on/dec/tc_stop/tc/ovr/pend = 0, dma_req=0, dma_rnw=1, dma_reswait_n=1, dma_addr/count/dma_wd/dma_data_toberead = 0; sync flops SHALL load the current toggle levels so reset raises no event.

Verification
REQ-040 addr=0x00FFFF, count=2, ctrl=0xA0, write toggle with data 0x5A -> dma_req, dma_rnw=0, dma_wd=0x5A, addr 0x010000 after ack, reswait low until done+1.
REQ-041 Read toggle, dma_rd=0xC3 at done -> dma_data_toberead=0xC3, dma_rnw=1.
REQ-042 dec=1, addr=0 -> addr=0x1FFFFF after ack; count 1->0 with tc_stop -> tc=1, dma_on=0, later toggles ignored.
REQ-043 Both toggles in the same cycle -> write then read transfer; second write toggle before service -> ovr=1, cleared by writing ctrl bit4.
REQ-044 dma_on cleared in BUSY -> done still accepted, reswait released, no further requests; rst asserted in REQ -> all REQ-039 values immediately.

Source files
------------

// File: rtl/dma_zx_stream.sv
// ZX-side DMA byte stream: each ZX read/write toggle becomes one memory
// transfer, holding the ZX in wait until the transfer completes.
module dma_zx_stream #(
    parameter int AW = 21,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_zxread_toggle,
    input  logic          dma_zxwrite_toggle,
    output logic          dma_reswait_n,
    input  logic [7:0]    dma_data_written,
    output logic [7:0]    dma_data_toberead,
    output logic          dma_on,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    input  logic          module_select,
    input  logic          write_strobe,
    input  logic [2:0]    regsel,
    output logic [AW-1:0] dma_addr,
    output logic [7:0]    dma_wd,
    input  logic [7:0]    dma_rd,
    output logic          dma_rnw,
    output logic          dma_req,
    input  logic          dma_ack,
    input  logic          dma_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    logic [2:0]    rd_sync, wr_sync;
    logic          rd_ev, wr_ev;
    logic [1:0]    state, state_n;
    logic          busy;
    logic          dec, tc_stop, tc, ovr;
    logic          pend_wr, pend_rd, tc_hit;
    logic [CW-1:0] count;
    logic [23:0]   addr_r, addr_w;
    logic [15:0]   cnt_r, cnt_w;

    logic          on_n, dec_n, tcs_n, tc_n, ovr_n;
    logic          pw_n, pr_n, hit_n, rnw_n, rsw_n;
    logic          take_wr, take_rd, done_tc, reg_wr;
    logic [AW-1:0] addr_n;
    logic [CW-1:0] cnt_n;
    logic [7:0]    wd_n, rdat_n;

    // Reset preloads the current toggle levels so no phantom event appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sync <= {3{dma_zxread_toggle}};
            wr_sync <= {3{dma_zxwrite_toggle}};
        end else begin
            rd_sync <= {rd_sync[1:0], dma_zxread_toggle};
            wr_sync <= {wr_sync[1:0], dma_zxwrite_toggle};
        end
    end

    assign rd_ev   = rd_sync[2] ^ rd_sync[1];
    assign wr_ev   = wr_sync[2] ^ wr_sync[1];
    assign busy    = (state != S_IDLE);
    assign dma_req = (state == S_REQ);
    assign addr_r  = 24'(dma_addr);
    assign cnt_r   = 16'(count);
    assign reg_wr  = module_select && write_strobe;

    always_comb begin
        state_n = state;
        on_n    = dma_on;
        dec_n   = dec;
        tcs_n   = tc_stop;
        tc_n    = tc;
        ovr_n   = ovr;
        pw_n    = pend_wr;
        pr_n    = pend_rd;
        hit_n   = tc_hit;
        addr_n  = dma_addr;
        cnt_n   = count;
        rnw_n   = dma_rnw;
        wd_n    = dma_wd;
        rdat_n  = dma_data_toberead;
        take_wr = 1'b0;
        take_rd = 1'b0;
        done_tc = 1'b0;
        addr_w  = addr_r;
        cnt_w   = cnt_r;

        case (state)
            S_IDLE: begin
                if (pend_wr) begin
                    take_wr = 1'b1;
                    rnw_n   = 1'b0;
                    state_n = S_REQ;
                end else if (pend_rd) begin
                    take_rd = 1'b1;
                    rnw_n   = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (dma_ack) begin
                    state_n = S_BUSY;
                    addr_n  = dec ? dma_addr - AW'(1) : dma_addr + AW'(1);
                    if (count != '0) begin
                        cnt_n = count - CW'(1);
                        if (count == CW'(1) && tc_stop)
                            hit_n = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (dma_done) begin
                    state_n = S_IDLE;
                    if (dma_rnw)
                        rdat_n = dma_rd;
                    done_tc = tc_hit;
                    hit_n   = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (take_wr) pw_n = 1'b0;
        if (take_rd) pr_n = 1'b0;

        if (reg_wr) begin
            case (regsel)
                3'd0, 3'd1, 3'd2: begin
                    if (!busy) begin
                        if (regsel == 3'd0) addr_w[7:0]   = din;
                        if (regsel == 3'd1) addr_w[15:8]  = din;
                        if (regsel == 3'd2) addr_w[23:16] = din;
                        addr_n = addr_w[AW-1:0];
                    end
                end
                3'd3: begin
                    on_n  = din[7];
                    dec_n = din[6];
                    tcs_n = din[5];
                    if (din[4]) begin
                        tc_n  = 1'b0;
                        ovr_n = 1'b0;
                    end
                    // Enabling an exhausted channel in stop mode ends at once.
                    if (din[7] && din[5] && count == '0) begin
                        tc_n = 1'b1;
                        on_n = 1'b0;
                    end
                end
                3'd4, 3'd5: begin
                    if (!busy) begin
                        if (regsel == 3'd4) cnt_w[7:0]  = din;
                        if (regsel == 3'd5) cnt_w[15:8] = din;
                        cnt_n = cnt_w[CW-1:0];
                    end
                end
                default: ;
            endcase
        end

        if (wr_ev && dma_on) begin
            if (pend_wr && !take_wr) ovr_n = 1'b1;
            pw_n = 1'b1;
            wd_n = dma_data_written;
        end
        if (rd_ev && dma_on) begin
            if (pend_rd && !take_rd) ovr_n = 1'b1;
            pr_n = 1'b1;
        end

        if (done_tc) begin
            tc_n = 1'b1;
            on_n = 1'b0;
        end

        if (!on_n) begin
            pw_n = 1'b0;
            pr_n = 1'b0;
        end

        rsw_n = !(pw_n || pr_n || state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            dma_on            <= 1'b0;
            dec               <= 1'b0;
            tc_stop           <= 1'b0;
            tc                <= 1'b0;
            ovr               <= 1'b0;
            pend_wr           <= 1'b0;
            pend_rd           <= 1'b0;
            tc_hit            <= 1'b0;
            dma_addr          <= '0;
            count             <= '0;
            dma_rnw           <= 1'b1;
            dma_wd            <= 8'h00;
            dma_data_toberead <= 8'h00;
            dma_reswait_n     <= 1'b1;
        end else begin
            state             <= state_n;
            dma_on            <= on_n;
            dec               <= dec_n;
            tc_stop           <= tcs_n;
            tc                <= tc_n;
            ovr               <= ovr_n;
            pend_wr           <= pw_n;
            pend_rd           <= pr_n;
            tc_hit            <= hit_n;
            dma_addr          <= addr_n;
            count             <= cnt_n;
            dma_rnw           <= rnw_n;
            dma_wd            <= wd_n;
            dma_data_toberead <= rdat_n;
            dma_reswait_n     <= rsw_n;
        end
    end

    always_comb begin
        dout = 8'h00;
        case (regsel)
            3'd0: dout = addr_r[7:0];
            3'd1: dout = addr_r[15:8];
            3'd2: dout = addr_r[23:16];
            3'd3: dout = {dma_on, dec, tc_stop, busy, ovr, tc, 2'b00};
            3'd4: dout = cnt_r[7:0];
            3'd5: dout = cnt_r[15:8];
            default: dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dma_zx_stream.sv
// Bench for dma_zx_stream: register vector table, directed corner
// sequences and a randomized block-transfer run against a memory model.
module tb_dma_zx_stream;

    localparam int AW = 21;
    localparam int CW = 16;
    localparam logic [23:0] AMASK = 24'h1F_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dma_zxread_toggle = 1'b0;
    logic          dma_zxwrite_toggle = 1'b0;
    logic          dma_reswait_n;
    logic [7:0]    dma_data_written = 8'h00;
    logic [7:0]    dma_data_toberead;
    logic          dma_on;
    logic [7:0]    din = 8'h00;
    logic [7:0]    dout;
    logic          module_select = 1'b0;
    logic          write_strobe = 1'b0;
    logic [2:0]    regsel = 3'd0;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wd;
    logic [7:0]    dma_rd = 8'h00;
    logic          dma_rnw;
    logic          dma_req;
    logic          dma_ack = 1'b0;
    logic          dma_done = 1'b0;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dma_zx_stream #(.AW(AW), .CW(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .dma_zxread_toggle  (dma_zxread_toggle),
        .dma_zxwrite_toggle (dma_zxwrite_toggle),
        .dma_reswait_n      (dma_reswait_n),
        .dma_data_written   (dma_data_written),
        .dma_data_toberead  (dma_data_toberead),
        .dma_on             (dma_on),
        .din                (din),
        .dout               (dout),
        .module_select      (module_select),
        .write_strobe       (write_strobe),
        .regsel             (regsel),
        .dma_addr           (dma_addr),
        .dma_wd             (dma_wd),
        .dma_rd             (dma_rd),
        .dma_rnw            (dma_rnw),
        .dma_req            (dma_req),
        .dma_ack            (dma_ack),
        .dma_done           (dma_done)
    );

    typedef struct {
        logic [2:0] sel;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] mem [int];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic reg_wr(input logic [2:0] sel, input logic [7:0] d);
        regsel = sel;
        din = d;
        module_select = 1'b1;
        write_strobe = 1'b1;
        tick();
        module_select = 1'b0;
        write_strobe = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] sel, output logic [7:0] d);
        regsel = sel;
        #1;
        d = dout;
    endtask

    task automatic tog_wr(input logic [7:0] d);
        dma_data_written = d;
        dma_zxwrite_toggle = ~dma_zxwrite_toggle;
    endtask

    task automatic tog_rd();
        dma_zxread_toggle = ~dma_zxread_toggle;
    endtask

    task automatic wait_req(input string nm, output bit ok);
        int n = 0;
        while (dma_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ok = (dma_req === 1'b1);
        check({nm, "_req"}, {31'b0, dma_req}, 32'd1);
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) tick();
        dma_ack = 1'b1;
        tick();
        dma_ack = 1'b0;
    endtask

    task automatic do_done(input int dly, input logic [7:0] rdata);
        repeat (dly) tick();
        dma_rd = rdata;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
    endtask

    task automatic wait_release(input string nm);
        int n = 0;
        while (dma_reswait_n !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_release"}, {31'b0, dma_reswait_n}, 32'd1);
    endtask

    task automatic quiet(input string nm, input int cyc);
        bit seen = 1'b0;
        repeat (cyc) begin
            tick();
            if (dma_req !== 1'b0 || dma_reswait_n !== 1'b1) seen = 1'b1;
        end
        check(nm, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  r, b0, b1, b2;
        logic [23:0] base, exp_addr;
        logic [7:0]  data;
        bit          ok, d, is_wr;
        int          n;

        vecs[0] = '{3'd0, 8'hA5, 8'hA5};
        vecs[1] = '{3'd1, 8'h3C, 8'h3C};
        vecs[2] = '{3'd2, 8'hFF, 8'h1F};
        vecs[3] = '{3'd4, 8'h12, 8'h12};
        vecs[4] = '{3'd5, 8'hFE, 8'hFE};
        vecs[5] = '{3'd6, 8'h77, 8'h00};
        vecs[6] = '{3'd7, 8'h55, 8'h00};
        vecs[7] = '{3'd3, 8'h60, 8'h60};
        vecs[8] = '{3'd3, 8'h10, 8'h00};
        vecs[9] = '{3'd2, 8'h0B, 8'h0B};

        do_reset();
        check("rst_req", {31'b0, dma_req}, 32'd0);
        check("rst_rnw", {31'b0, dma_rnw}, 32'd1);
        check("rst_reswait", {31'b0, dma_reswait_n}, 32'd1);
        check("rst_addr", 32'(dma_addr), 32'd0);
        check("rst_wd", 32'(dma_wd), 32'd0);
        check("rst_rdata", 32'(dma_data_toberead), 32'd0);
        reg_rd(3'd3, r);
        check("rst_status", 32'(r), 32'd0);

        foreach (vecs[i]) begin
            reg_wr(vecs[i].sel, vecs[i].wdata);
            reg_rd(vecs[i].sel, r);
            check($sformatf("reg_vec%0d", i), 32'(r), 32'(vecs[i].exp));
        end

        // Write transfer with address carry, busy write ignored
        do_reset();
        reg_wr(3'd0, 8'hFF);
        reg_wr(3'd1, 8'hFF);
        reg_wr(3'd2, 8'h00);
        reg_wr(3'd4, 8'h02);
        reg_wr(3'd5, 8'h00);
        reg_wr(3'd3, 8'hA0);
        reg_rd(3'd3, r);
        check("on_status", 32'(r), 32'hA0);
        tog_wr(8'h5A);
        wait_req("w1", ok);
        check("w1_rnw", {31'b0, dma_rnw}, 32'd0);
        check("w1_wd", 32'(dma_wd), 32'h5A);
        check("w1_wait", {31'b0, dma_reswait_n}, 32'd0);
        reg_wr(3'd0, 8'h77);
        check("w1_busy_addr", 32'(dma_addr), 32'h00FFFF);
        do_ack(0);
        check("w1_addr", 32'(dma_addr), 32'h010000);
        check("w1_req_drop", {31'b0, dma_req}, 32'd0);
        tick();
        check("w1_wait_busy", {31'b0, dma_reswait_n}, 32'd0);
        do_done(0, 8'h00);
        check("w1_release", {31'b0, dma_reswait_n}, 32'd1);

        // Read transfer finishing the count in stop mode
        tog_rd();
        wait_req("r1", ok);
        check("r1_rnw", {31'b0, dma_rnw}, 32'd1);
        do_ack(1);
        do_done(2, 8'hC3);
        check("r1_data", 32'(dma_data_toberead), 32'hC3);
        check("r1_rnw_after", {31'b0, dma_rnw}, 32'd1);
        check("r1_on", {31'b0, dma_on}, 32'd0);
        reg_rd(3'd3, r);
        check("r1_status_tc", 32'(r), 32'h24);

        // Decrement wrap and terminal count
        do_reset();
        reg_wr(3'd4, 8'h01);
        reg_wr(3'd3, 8'hE0);
        tog_wr(8'h11);
        wait_req("dec", ok);
        do_ack(0);
        check("dec_addr", 32'(dma_addr), 32'h1FFFFF);
        do_done(1, 8'h00);
        reg_rd(3'd3, r);
        check("dec_status", 32'(r), 32'h64);
        tog_rd();
        quiet("dec_ignored", 10);

        // Enable with zero count in stop mode
        do_reset();
        reg_wr(3'd3, 8'hA0);
        reg_rd(3'd3, r);
        check("zero_cnt_tc", 32'(r), 32'h24);
        reg_wr(3'd3, 8'h10);
        reg_rd(3'd3, r);
        check("tc_clear", 32'(r), 32'h00);

        // Simultaneous toggles, then overrun
        do_reset();
        reg_wr(3'd3, 8'h80);
        tog_wr(8'h21);
        tog_rd();
        wait_req("both_w", ok);
        check("both_w_rnw", {31'b0, dma_rnw}, 32'd0);
        do_ack(0);
        do_done(0, 8'h00);
        wait_req("both_r", ok);
        check("both_r_rnw", {31'b0, dma_rnw}, 32'd1);
        check("both_wait", {31'b0, dma_reswait_n}, 32'd0);
        do_ack(0);
        do_done(0, 8'h44);
        check("both_rdata", 32'(dma_data_toberead), 32'h44);
        tog_wr(8'h31);
        wait_req("ov1", ok);
        tog_wr(8'h32);
        repeat (4) tick();
        tog_wr(8'h33);
        repeat (4) tick();
        reg_rd(3'd3, r);
        check("ovr_status", 32'(r), 32'h98);
        do_ack(0);
        do_done(0, 8'h00);
        wait_req("ov2", ok);
        check("ov2_wd", 32'(dma_wd), 32'h33);
        do_ack(0);
        do_done(0, 8'h00);
        reg_wr(3'd3, 8'h90);
        reg_rd(3'd3, r);
        check("ovr_clear", 32'(r), 32'h80);

        // Disable mid-transfer
        do_reset();
        reg_wr(3'd3, 8'h80);
        tog_rd();
        wait_req("off", ok);
        do_ack(0);
        reg_wr(3'd3, 8'h00);
        check("off_on", {31'b0, dma_on}, 32'd0);
        check("off_wait", {31'b0, dma_reswait_n}, 32'd0);
        do_done(0, 8'h7E);
        check("off_release", {31'b0, dma_reswait_n}, 32'd1);
        check("off_rdata", 32'(dma_data_toberead), 32'h7E);
        tog_wr(8'h01);
        quiet("off_quiet", 10);

        // Asynchronous reset while requesting
        do_reset();
        reg_wr(3'd0, 8'h05);
        reg_wr(3'd3, 8'h80);
        tog_wr(8'h33);
        wait_req("arst", ok);
        rst = 1'b1;
        #1;
        check("arst_req", {31'b0, dma_req}, 32'd0);
        check("arst_rnw", {31'b0, dma_rnw}, 32'd1);
        check("arst_wait", {31'b0, dma_reswait_n}, 32'd1);
        check("arst_addr", 32'(dma_addr), 32'd0);
        check("arst_wd", 32'(dma_wd), 32'd0);
        check("arst_on", {31'b0, dma_on}, 32'd0);
        reg_rd(3'd3, r);
        check("arst_status", 32'(r), 32'd0);
        tick();
        rst = 1'b0;
        tog_rd();
        quiet("arst_quiet", 10);

        // Randomized blocks against a flat memory model
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            base = 24'($urandom) & AMASK;
            n = $urandom_range(1, 12);
            d = 1'($urandom_range(0, 1));
            reg_wr(3'd0, base[7:0]);
            reg_wr(3'd1, base[15:8]);
            reg_wr(3'd2, base[23:16]);
            reg_wr(3'd4, 8'(n));
            reg_wr(3'd5, 8'h00);
            reg_wr(3'd3, {1'b1, d, 6'b100000});
            exp_addr = base;
            for (int k = 0; k < n; k++) begin
                is_wr = 1'($urandom_range(0, 1));
                data = 8'($urandom);
                if (is_wr) tog_wr(data);
                else tog_rd();
                wait_req($sformatf("rnd%0d_%0d", blk, k), ok);
                if (!ok) break;
                check("rnd_addr", 32'(dma_addr), 32'(exp_addr));
                check("rnd_rnw", {31'b0, dma_rnw}, {31'b0, !is_wr});
                if (is_wr) begin
                    check("rnd_wd", 32'(dma_wd), 32'(data));
                    mem[int'(exp_addr)] = data;
                end else if (mem.exists(int'(exp_addr))) begin
                    data = mem[int'(exp_addr)];
                end
                do_ack($urandom_range(0, 3));
                do_done($urandom_range(0, 3), data);
                if (!is_wr)
                    check("rnd_rdata", 32'(dma_data_toberead), 32'(data));
                exp_addr = (d ? exp_addr - 24'd1 : exp_addr + 24'd1) & AMASK;
                wait_release("rnd");
            end
            reg_rd(3'd0, b0);
            reg_rd(3'd1, b1);
            reg_rd(3'd2, b2);
            check("rnd_final_addr", 32'({b2, b1, b0}), 32'(exp_addr));
            reg_rd(3'd3, r);
            check("rnd_final_status", 32'(r),
                  32'({1'b0, d, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00}));
            reg_wr(3'd3, 8'h10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
